// File: rtl/aes_key_loader_pkg.sv
// Shared definitions for the AES key loader: keylen encodings, word counts, key width, FSM states.
package aes_key_loader_pkg;

    localparam int KEY_W  = 256;
    localparam int WORD_W = 32;

    localparam logic [1:0] AES_128_BIT_KEY = 2'd0;
    localparam logic [1:0] AES_256_BIT_KEY = 2'd1;
    localparam logic [1:0] AES_192_BIT_KEY = 2'd2;
    localparam logic [1:0] AES_BAD_KEY     = 2'd3;

    localparam int WORDS_128 = 4;
    localparam int WORDS_192 = 6;
    localparam int WORDS_256 = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_WAIT_CLR,
        ST_WAIT_RDY,
        ST_DONE
    } ld_state_e;

    // Index of the final key word for a given keylen encoding.
    function automatic logic [2:0] last_word_idx(input logic [1:0] kl);
        case (kl)
            AES_256_BIT_KEY: return 3'(WORDS_256 - 1);
            AES_192_BIT_KEY: return 3'(WORDS_192 - 1);
            default:         return 3'(WORDS_128 - 1);
        endcase
    endfunction

endpackage

// File: rtl/aes_key_loader_if.sv
// Host-side config/word stream plus the aes_key_mem key/init/ready link of the key loader.
interface aes_key_loader_if;
    import aes_key_loader_pkg::*;

    logic              cfg_valid;
    logic [1:0]        cfg_keylen;
    logic              cfg_ready;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic              abort;
    logic [KEY_W-1:0]  key;
    logic [1:0]        keylen;
    logic              init;
    logic              km_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cfg_valid, cfg_keylen, word_valid, word_data, abort, km_ready,
        input  cfg_ready, word_ready, key, keylen, init, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_keylen, word_valid, word_data, abort, km_ready,
        output cfg_ready, word_ready, key, keylen, init, busy, done, err
    );

endinterface

// File: rtl/aes_key_loader.sv
// Word-serial key assembly for aes_key_mem, then init pulse and ready tracking with timeout.
// Latency: last word at t -> init at t+1; done one cycle after km_ready rises. Words stall via word_ready (LOAD only).
// AES_KEY_LOADER_ZEROIZE_EN: clear key after DONE and on timeout.
module aes_key_loader
    import aes_key_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    aes_key_loader_if.slave bus
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    ld_state_e         state;
    logic [KEY_W-1:0]  key_q;
    logic [1:0]        keylen_q;
    logic [2:0]        cnt_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              init_q;
    logic              done_q;
    logic              err_q;
    logic              tmr_exp;

    assign tmr_exp = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            key_q    <= '0;
            keylen_q <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            init_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            init_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cfg_valid && !bus.abort) begin
                        if (bus.cfg_keylen == AES_BAD_KEY) begin
                            err_q <= 1'b1;
                        end else begin
                            keylen_q <= bus.cfg_keylen;
                            key_q    <= '0;
                            cnt_q    <= '0;
                            state    <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.abort) begin
                        key_q <= '0;
                        cnt_q <= '0;
                        state <= ST_IDLE;
                    end else if (bus.word_valid) begin
                        // Word 0 lands in key[255:224], word 7 in key[31:0].
                        key_q[{3'd7 - cnt_q, 5'd0} +: WORD_W] <= bus.word_data;
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == last_word_idx(keylen_q)) begin
                            init_q <= 1'b1;
                            state  <= ST_INIT;
                        end
                    end
                end
                ST_INIT: begin
                    tmr_q <= '0;
                    state <= ST_WAIT_CLR;
                end
                ST_WAIT_CLR, ST_WAIT_RDY: begin
                    tmr_q <= tmr_q + 1'b1;
                    if (state == ST_WAIT_CLR && !bus.km_ready) begin
                        state <= ST_WAIT_RDY;
                    end else if (state == ST_WAIT_RDY && bus.km_ready) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else if (tmr_exp) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
`ifdef AES_KEY_LOADER_ZEROIZE_EN
                        key_q <= '0;
`endif
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
`ifdef AES_KEY_LOADER_ZEROIZE_EN
                    key_q <= '0;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.key        = key_q;
    assign bus.keylen     = keylen_q;
    assign bus.init       = init_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.cfg_ready  = (state == ST_IDLE);
    assign bus.word_ready = (state == ST_LOAD);
    assign bus.busy       = (state != ST_IDLE);

endmodule
